instr_encode_loader: RTL and testbench

INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

---
 rtl/mips_isa_pkg.sv | 43 ++++
 rtl/instr_field_encoder.sv | 38 +++
 rtl/instr_encode_loader.sv | 114 +++++++++++
 tb/tb_instr_encode_loader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS mnemonic enum and opcode/func constants
package mips_isa_pkg;

  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_SLT  = 4'd4,
    MN_JR   = 4'd5,
    MN_ADDI = 4'd6,
    MN_SLTI = 4'd7,
    MN_LW   = 4'd8,
    MN_SW   = 4'd9,
    MN_J    = 4'd10,
    MN_JAL  = 4'd11,
    MN_BEQ  = 4'd12,
    MN_BNE  = 4'd13
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'h00, fn};
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// rtl/instr_field_encoder.sv - combinational packing of instruction fields into a word
import mips_isa_pkg::*;

module instr_field_encoder (
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the instruction format from the mnemonic; codes 14-15 are illegal
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  word = pack_r(rs, rt, rd, FN_ADD);
      MN_SUB:  word = pack_r(rs, rt, rd, FN_SUB);
      MN_AND:  word = pack_r(rs, rt, rd, FN_AND);
      MN_OR:   word = pack_r(rs, rt, rd, FN_OR);
      MN_SLT:  word = pack_r(rs, rt, rd, FN_SLT);
      MN_JR:   word = {OP_RTYPE, rs, 15'h0000, FN_JR};
      MN_ADDI: word = {OP_ADDI, rs, rt, imm};
      MN_SLTI: word = {OP_SLTI, rs, rt, imm};
      MN_LW:   word = {OP_LW, rs, rt, imm};
      MN_SW:   word = {OP_SW, rs, rt, imm};
      MN_BEQ:  word = {OP_BEQ, rs, rt, imm};
      MN_BNE:  word = {OP_BNE, rs, rt, imm};
      MN_J:    word = {OP_J, target};
      MN_JAL:  word = {OP_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - encodes instructions and loads them into instruction memory
import mips_isa_pkg::*;

module instr_encode_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     finish,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               mnem,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [15:0]              imm,
  input  logic [25:0]              target,
  output logic                     im_we,
  output logic [31:0]              im_addr,
  output logic [31:0]              im_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     done,
  output logic                     err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FULL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e      state;
  logic        fin_pend;
  logic [31:0] enc_word;
  logic        enc_illegal;

  instr_field_encoder u_enc (
    .mnem    (mnem),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .imm     (imm),
    .target  (target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Status flags are pure decodes of the state register, so they change only on clock edges
  assign in_ready = (state == ST_LOAD);
  assign full     = (state == ST_FULL);
  assign done     = (state == ST_DONE);

  // Session FSM: accept, one-cycle write pulse, pointer/count advance, finish handling
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      im_we    <= 1'b0;
      im_addr  <= BASE_ADDR;
      im_wdata <= 32'h0;
      count    <= '0;
      err      <= 1'b0;
      fin_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_LOAD;
            count    <= '0;
            err      <= 1'b0;
            im_addr  <= BASE_ADDR;
            fin_pend <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_valid && enc_illegal) begin
            // Illegal words are dropped; only the sticky error records them
            err <= 1'b1;
            if (finish) state <= ST_DONE;
          end else if (in_valid) begin
            im_wdata <= enc_word;
            im_we    <= 1'b1;
            fin_pend <= finish;
            state    <= ST_WRITE;
          end else if (finish) begin
            state <= ST_DONE;
          end
        end
        ST_WRITE: begin
          im_we    <= 1'b0;
          im_addr  <= im_addr + 32'd4;
          count    <= count + CW'(1);
          fin_pend <= 1'b0;
          // A pending finish takes priority over filling up on the last slot
          if (fin_pend || finish)             state <= ST_DONE;
          else if (count + CW'(1) == DEPTH_C) state <= ST_FULL;
          else                                state <= ST_LOAD;
        end
        ST_FULL: begin
          if (finish) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - scoreboard testbench for instr_encode_loader
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst, start, finish, in_valid, in_ready;
  logic [3:0]  mnem;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        im_we;
  logic [31:0] im_addr, im_wdata;
  logic [2:0]  count;
  logic        full, done, err;

  int passed = 0;
  int total  = 0;
  int writes = 0;
  logic [63:0] exp_q[$];

  instr_encode_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .full(full), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write pulse is matched against the oldest expected {addr,data}
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", im_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", im_addr, e[63:32]);
        chk("write_data", im_wdata, e[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("in_ready_timeout", {31'h0, in_ready}, 32'h1);
  endtask

  // Present one instruction for exactly one accepted cycle; push the expected write if legal
  task automatic issue(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] i, input logic [25:0] g,
                       input logic fin, input logic push, input logic [31:0] ea,
                       input logic [31:0] ed);
    wait_ready();
    mnem = m; rs = s; rt = t; rd = d; imm = i; target = g;
    in_valid = 1'b1;
    finish = fin;
    if (push) exp_q.push_back({ea, ed});
    @(negedge clk);
    in_valid = 1'b0;
    finish = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    mnem = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; target = 26'd0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_status", {21'h0, im_we, count, full, done, err, in_ready, 3'h0}, 32'h0);
    chk("reset_addr", im_addr, 32'h0);
    chk("reset_wdata", im_wdata, 32'h0);

    // ADD then status
    pulse_start();
    chk("load_in_ready", {31'h0, in_ready}, 32'h1);
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0, 32'h0022_1820);
    idle(1);
    chk("count_after_add", {29'h0, count}, 32'd1);
    issue(4'd6, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b0, 1'b1, 32'h4, 32'h2001_0005);
    issue(4'd13, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0, 1'b0, 1'b1, 32'h8, 32'h1422_FFFE);
    idle(1);
    finish = 1'b1; @(negedge clk); finish = 1'b0;
    chk("done_after_finish", {31'h0, done}, 32'h1);
    chk("count_session1", {29'h0, count}, 32'd3);

    // New session restarts the pointer: JAL, JR
    pulse_start();
    chk("count_cleared", {29'h0, count}, 32'd0);
    issue(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b0, 1'b1, 32'h0, 32'h0C00_0010);
    issue(4'd5, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h4, 32'h03E0_0008);
    idle(1);

    // Illegal mnemonic: no write, sticky err, next legal word at unchanged address
    finish = 1'b1; @(negedge clk); finish = 1'b0;
    pulse_start();
    issue(4'd14, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("illegal_err", {31'h0, err}, 32'h1);
    chk("illegal_ready_back", {31'h0, in_ready}, 32'h1);
    chk("illegal_count", {29'h0, count}, 32'd0);
    issue(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0, 32'h0085_3022);
    idle(1);
    chk("err_sticky", {31'h0, err}, 32'h1);
    finish = 1'b1; @(negedge clk); finish = 1'b0;

    // Fill DEPTH=4 then a fifth instruction that must not be accepted
    pulse_start();
    chk("err_cleared", {31'h0, err}, 32'h0);
    writes = 0;
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0, 32'h0022_1820);
    issue(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 1'b1, 32'h4, 32'h0085_3022);
    issue(4'd8, 5'd1, 5'd2, 5'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'h8, 32'h8C22_0004);
    issue(4'd9, 5'd1, 5'd2, 5'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'hC, 32'hAC22_0004);
    idle(1);
    mnem = 4'd3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_flag", {31'h0, full}, 32'h1);
      chk("full_not_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_writes", writes, 32'd4);
    finish = 1'b1; @(negedge clk); finish = 1'b0;
    chk("full_done", {31'h0, done}, 32'h1);
    chk("full_count", {29'h0, count}, 32'd4);

    // Finish coincident with accept: word still written, then DONE
    pulse_start();
    issue(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1, 1'b1, 32'h0, 32'h0BFF_FFFF);
    chk("pend_not_done_in_write", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("pend_done", {31'h0, done}, 32'h1);
    chk("pend_count", {29'h0, count}, 32'd1);

    // Reset during WRITE with a pending finish
    pulse_start();
    issue(4'd12, 5'd3, 5'd4, 5'd0, 16'h0010, 26'h0, 1'b1, 1'b1, 32'h0, 32'h1064_0010);
    chk("we_in_write", {31'h0, im_we}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_status", {21'h0, im_we, count, full, done, err, in_ready, 3'h0}, 32'h0);
    chk("rst_addr", im_addr, 32'h0);
    chk("rst_wdata", im_wdata, 32'h0);
    idle(2);
    chk("rst_no_pending_done", {31'h0, done}, 32'h0);
    finish = 1'b1; @(negedge clk); finish = 1'b0;
    chk("finish_ignored_idle", {31'h0, done}, 32'h0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
